// File: rtl/i2c_peripheral.sv
`timescale 1ns/1ps
// i2c_peripheral: I2C target (responder) that oversamples SCL/SDA on the
// system clock, matches a fixed 7-bit address, receives written bytes and
// serialises read bytes supplied by the host logic.
//
// Ports:
//   clk              system clock (>= 16x SCL)
//   reset            asynchronous, active-low reset
//   scl, sda_in      bus clock / bus data as seen on the pads
//   sda_out, sda_oe  open-drain SDA drive (sda_oe = 1 pulls SDA low)
//   received_data    last byte written by the controller
//   received_valid   one-clk pulse when received_data updates
//   transmit_data    next read byte, captured the clk after transmit_request
//   transmit_request one-clk pulse requesting the next read byte
//   read_write       R/W bit of the current addressed transaction
//   busy             high from address ACK until STOP/START/NACK
//   nack_received    one-clk pulse when the controller NACKs a read byte
//   transfer_done    one-clk pulse on STOP ending a busy transaction
module i2c_peripheral #(
  parameter logic [6:0]  ADDRESS     = 7'h55,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] received_data,
  output logic       received_valid,
  input  logic [7:0] transmit_data,
  output logic       transmit_request,
  output logic       read_write,
  output logic       busy,
  output logic       nack_received,
  output logic       transfer_done
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_LOAD, TX_DATA, TX_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_p_q, sda_p_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d, byte_in;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic       oe_q, oe_d, rw_q, rw_d, busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       nack_q, nack_d, done_q, done_d;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_p_q;
  assign scl_fall  = ~scl_s & scl_p_q;
  // SCL must be high in both samples: an SDA edge coinciding with an SCL
  // edge is a data transition, not a bus condition.
  assign start_det = ~sda_s & sda_p_q & scl_s & scl_p_q;
  assign stop_det  = sda_s & ~sda_p_q & scl_s & scl_p_q;
  assign byte_in   = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    oe_d       = oe_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    nack_d     = 1'b0;
    done_d     = 1'b0;
    if (stop_det) begin
      state_d  = IDLE;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      done_d   = busy_q;
      bitcnt_d = '0;
    end else if (start_det) begin
      state_d  = ADDR;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      bitcnt_d = '0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = '0;
            if (byte_in[7:1] == ADDRESS) begin
              state_d = ADDR_ACK;
              rw_d    = byte_in[0];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // First fall drives the ACK; on reads the ACK rise hands over to
        // TX_LOAD, whose fall replaces the release with the first data bit.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d   = 1'b1;
              busy_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = RX_DATA;
            end
          end else if (scl_rise && oe_q && rw_q) begin
            tx_req_d = 1'b1;
            state_d  = TX_LOAD;
          end
        end
        RX_DATA: if (scl_rise) begin
          shift_d  = byte_in;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            bitcnt_d   = '0;
            rx_data_d  = byte_in;
            rx_valid_d = 1'b1;
            state_d    = RX_ACK;
          end
        end
        RX_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            state_d = RX_DATA;
          end
        end
        TX_LOAD: begin
          if (tx_req_q) shift_d = transmit_data;
          if (scl_fall) begin
            oe_d     = ~shift_q[7];
            bitcnt_d = '0;
            state_d  = TX_DATA;
          end
        end
        TX_DATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bitcnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = TX_ACK;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        TX_ACK: if (scl_rise) begin
          if (!sda_s) begin
            tx_req_d = 1'b1;
            state_d  = TX_LOAD;
          end else begin
            nack_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= IDLE;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      oe_q       <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      oe_q       <= oe_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
    end
  end

  assign sda_out          = 1'b0;
  assign sda_oe           = oe_q;
  assign received_data    = rx_data_q;
  assign received_valid   = rx_valid_q;
  assign transmit_request = tx_req_q;
  assign read_write       = rw_q;
  assign busy             = busy_q;
  assign nack_received    = nack_q;
  assign transfer_done    = done_q;

endmodule
